// File: rtl/dpb_pkg.sv
// Shared types and width helpers for the dirty pointer broker.
//   dpb_fsm_e : refill FSM states
//   ptr_t     : pointer type at the default pointer width
//   occ_w()   : width of a fill-level counter for a given FIFO depth
//   idx_w()   : width of an index into N entries (at least 1 bit)
package dpb_pkg;

  localparam int unsigned PTR_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } dpb_fsm_e;

  typedef logic [PTR_W_DEF-1:0] ptr_t;

  function automatic int unsigned occ_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dpb_mc_if.sv
// PFS and client-side handshake bundle of the dirty pointer broker.
//   pfs_req_valid/ready : burst request to PFS
//   pfs_ptr_valid/ptr   : pointers returned by PFS
//   cli_req             : level request per client
//   cli_gnt/cli_ptr     : one-hot grant and the delivered pointer
// master = broker side, slave = PFS/client side.
interface dpb_mc_if import dpb_pkg::*; #(
  parameter int unsigned N_CLIENTS = 2,
  parameter int unsigned PTR_W     = PTR_W_DEF
) ();

  logic                 pfs_req_valid;
  logic                 pfs_req_ready;
  logic                 pfs_ptr_valid;
  logic [PTR_W-1:0]     pfs_ptr;
  logic [N_CLIENTS-1:0] cli_req;
  logic [N_CLIENTS-1:0] cli_gnt;
  logic [PTR_W-1:0]     cli_ptr;

  modport master (
    output pfs_req_valid, cli_gnt, cli_ptr,
    input  pfs_req_ready, pfs_ptr_valid, pfs_ptr, cli_req
  );

  modport slave (
    input  pfs_req_valid, cli_gnt, cli_ptr,
    output pfs_req_ready, pfs_ptr_valid, pfs_ptr, cli_req
  );

endinterface

// File: rtl/dpb_rr_arb.sv
// Round-robin arbiter over N_CLIENTS requesters.
//   clk, rst_n : clock, synchronous active-low reset
//   req        : request vector
//   advance    : a grant was taken; rotate priority past the winner
//   gnt_c      : combinational one-hot grant (zero when req is zero)
module dpb_rr_arb import dpb_pkg::*; #(
  parameter int unsigned N_CLIENTS = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_CLIENTS-1:0] req,
  input  logic                 advance,
  output logic [N_CLIENTS-1:0] gnt_c
);

  localparam int unsigned IDX_W = idx_w(N_CLIENTS);

  logic [IDX_W-1:0] prio;
  logic [IDX_W-1:0] win;
  logic             found;
  int unsigned      idx;

  // First requester at or after the priority pointer, wrapping around.
  always_comb begin
    gnt_c = '0;
    win   = prio;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 0; i < N_CLIENTS; i++) begin
      idx = (32'(prio) + i) % N_CLIENTS;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = IDX_W'(idx);
      end
    end
    if (found) gnt_c[win] = 1'b1;
  end

  // Priority register: next search starts one past the last winner.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio <= '0;
    end else if (advance) begin
      prio <= (32'(win) == N_CLIENTS - 1) ? '0 : win + IDX_W'(1);
    end
  end

endmodule

// File: rtl/dpb_mc.sv
// Multi-client dirty pointer broker: refills a local FIFO from PFS in
// REQ_BURST-sized bursts and hands pointers to clients round-robin.
//   clk, rst_n : clock, synchronous active-low reset
//   cfg_en     : allow new refill requests
//   cfg_low_wm : refill when occupancy drops below this level
//   bus        : PFS request/return and client request/grant bundle
//   occupancy  : current FIFO fill level
//   err_unexp  : sticky, pointer seen with no burst outstanding
module dpb_mc import dpb_pkg::*; #(
  parameter int unsigned N_CLIENTS = 2,
  parameter int unsigned PTR_W     = PTR_W_DEF,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned REQ_BURST = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cfg_en,
  input  logic [$clog2(DEPTH+1)-1:0] cfg_low_wm,
  dpb_mc_if.master                   bus,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic                       err_unexp
);

  localparam int unsigned OCC_W = occ_w(DEPTH);
  localparam int unsigned AW    = idx_w(DEPTH);
  localparam int unsigned RX_W  = $clog2(REQ_BURST + 1);

  dpb_fsm_e             state, state_nxt;
  logic [RX_W-1:0]      rx_cnt, rx_cnt_nxt;
  logic [PTR_W-1:0]     mem [DEPTH];
  logic [AW-1:0]        wr_idx, rd_idx;
  logic [N_CLIENTS-1:0] arb_gnt_c;
  logic                 hs_c, push_c, pop_c, unexp_c, empty_c, full_c, refill_ok_c;

  // A pointer is accepted only inside a burst, including the handshake cycle.
  assign hs_c        = (state == REQ) && bus.pfs_req_ready;
  assign push_c      = bus.pfs_ptr_valid && ((state == WAIT) || hs_c);
  assign unexp_c     = bus.pfs_ptr_valid && !push_c;
  assign empty_c     = (occupancy == '0);
  assign full_c      = (32'(occupancy) == DEPTH);
  assign pop_c       = !empty_c && (|bus.cli_req);
  assign refill_ok_c = (32'(occupancy) < 32'(cfg_low_wm)) &&
                       (32'(occupancy) + REQ_BURST <= DEPTH);

  // Refill FSM next state.
  always_comb begin
    state_nxt  = state;
    rx_cnt_nxt = rx_cnt;
    unique case (state)
      IDLE: if (cfg_en && refill_ok_c) state_nxt = REQ;
      REQ: begin
        if (bus.pfs_req_ready) begin
          rx_cnt_nxt = push_c ? RX_W'(1) : '0;
          state_nxt  = (push_c && (REQ_BURST == 1)) ? IDLE : WAIT;
        end
      end
      WAIT: begin
        if (push_c) begin
          rx_cnt_nxt = rx_cnt + RX_W'(1);
          if (32'(rx_cnt) + 1 == REQ_BURST) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state and registered request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state             <= IDLE;
      rx_cnt            <= '0;
      bus.pfs_req_valid <= 1'b0;
    end else begin
      state             <= state_nxt;
      rx_cnt            <= rx_cnt_nxt;
      bus.pfs_req_valid <= (state_nxt == REQ);
    end
  end

  // FIFO storage, not reset.
  always_ff @(posedge clk) begin
    if (push_c) mem[wr_idx] <= bus.pfs_ptr;
  end

  // FIFO indices and fill level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_idx    <= '0;
      rd_idx    <= '0;
      occupancy <= '0;
    end else begin
      if (push_c) wr_idx <= (32'(wr_idx) == DEPTH - 1) ? '0 : wr_idx + AW'(1);
      if (pop_c)  rd_idx <= (32'(rd_idx) == DEPTH - 1) ? '0 : rd_idx + AW'(1);
      occupancy <= occupancy + OCC_W'(push_c) - OCC_W'(pop_c);
    end
  end

  // Grant output; pointer holds between grants.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.cli_gnt <= '0;
      bus.cli_ptr <= '0;
      err_unexp   <= 1'b0;
    end else begin
      bus.cli_gnt <= pop_c ? arb_gnt_c : '0;
      if (pop_c)   bus.cli_ptr <= mem[rd_idx];
      if (unexp_c) err_unexp   <= 1'b1;
    end
  end

  dpb_rr_arb #(.N_CLIENTS(N_CLIENTS)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (bus.cli_req),
    .advance (pop_c),
    .gnt_c   (arb_gnt_c)
  );

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push_c && full_c));

endmodule
